// File: rtl/cim_core_reg_arbiter_if.sv
// Requester-side and register-bus signals of cim_core_reg_arbiter.
// slave = arbiter view, master = view of the requesters/register file side.
interface cim_core_reg_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ-1:0]            req_write_i;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i;
  logic [NUM_REQ*STRB_WIDTH-1:0] req_wstrb_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic [DATA_WIDTH-1:0]         req_rdata_o;
  logic                          req_error_o;

  logic                          out_valid_o;
  logic                          out_write_o;
  logic [ADDR_WIDTH-1:0]         out_addr_o;
  logic [DATA_WIDTH-1:0]         out_wdata_o;
  logic [STRB_WIDTH-1:0]         out_wstrb_o;
  logic                          out_ready_i;
  logic [DATA_WIDTH-1:0]         out_rdata_i;
  logic                          out_error_i;

  logic [NUM_REQ-1:0]            grant_o;
  logic                          busy_o;
  logic                          timeout_o;

  modport slave (
    input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_wstrb_i,
    output req_ready_o, req_rdata_o, req_error_o,
    output out_valid_o, out_write_o, out_addr_o, out_wdata_o, out_wstrb_o,
    input  out_ready_i, out_rdata_i, out_error_i,
    output grant_o, busy_o, timeout_o
  );

  modport master (
    output req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_wstrb_i,
    input  req_ready_o, req_rdata_o, req_error_o,
    input  out_valid_o, out_write_o, out_addr_o, out_wdata_o, out_wstrb_o,
    output out_ready_i, out_rdata_i, out_error_i,
    input  grant_o, busy_o, timeout_o
  );
endinterface

// File: rtl/cim_core_reg_arbiter.sv
// Round-robin arbiter for the CIM core register bus; grant held for one full transfer.
// Optional watchdog enabled by defining CIM_REG_ARB_TIMEOUT_EN.
module cim_core_reg_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  cim_core_reg_arbiter_if.slave bus
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned IDX_W      = $clog2(NUM_REQ);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   r_gidx;
  logic [NUM_REQ-1:0] r_grant;

  logic [ADDR_WIDTH-1:0] w_addr_a  [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_wdata_a [NUM_REQ];
  logic [STRB_WIDTH-1:0] w_wstrb_a [NUM_REQ];

  logic             w_busy, w_gvalid, w_gwrite, w_ack, w_timeout, w_done, w_any;
  logic [IDX_W-1:0] w_win, w_idx, w_next;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_addr_a[gi]  = bus.req_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wdata_a[gi] = bus.req_wdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
    assign w_wstrb_a[gi] = bus.req_wstrb_i[gi*STRB_WIDTH +: STRB_WIDTH];
  end

  // First valid requester at or after the round-robin pointer, wrapping.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_idx = IDX_W'((32'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_any && bus.req_valid_i[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  assign w_busy   = (r_state == S_BUSY);
  assign w_gvalid = w_busy & bus.req_valid_i[r_gidx];
  assign w_gwrite = bus.req_write_i[r_gidx];
  assign w_ack    = w_gvalid & bus.out_ready_i;
  assign w_done   = w_ack | w_timeout;
  assign w_next   = (r_gidx == IDX_W'(NUM_REQ - 1)) ? '0 : r_gidx + 1'b1;

`ifdef CIM_REG_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] r_cnt;
  // An ack in the expiry cycle wins over the watchdog.
  assign w_timeout = w_gvalid & ~bus.out_ready_i & (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYCLES > 1);
  assign w_timeout    = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= '0;
      r_gidx   <= '0;
      r_grant  <= '0;
`ifdef CIM_REG_ARB_TIMEOUT_EN
      r_cnt    <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state <= S_BUSY;
            r_gidx  <= w_win;
            r_grant <= NUM_REQ'(1) << w_win;
`ifdef CIM_REG_ARB_TIMEOUT_EN
            r_cnt   <= '0;
`endif
          end
        end
        S_BUSY: begin
          if (w_done) begin
            r_state  <= S_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= w_next;
          end else if (!w_gvalid) begin
            // Requester withdrew mid-transfer: abandon without advancing the pointer.
            r_state <= S_IDLE;
            r_grant <= '0;
          end
`ifdef CIM_REG_ARB_TIMEOUT_EN
          else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.out_valid_o = w_gvalid;
  assign bus.out_write_o = w_busy & w_gwrite;
  assign bus.out_addr_o  = w_busy ? w_addr_a[r_gidx]  : '0;
  assign bus.out_wdata_o = w_busy ? w_wdata_a[r_gidx] : '0;
  assign bus.out_wstrb_o = w_busy ? w_wstrb_a[r_gidx] : '0;

  assign bus.req_ready_o = w_done ? r_grant : '0;
  assign bus.req_rdata_o = (w_ack && !w_gwrite) ? bus.out_rdata_i : '0;
  assign bus.req_error_o = w_ack ? bus.out_error_i : w_timeout;

  assign bus.grant_o   = r_grant;
  assign bus.busy_o    = w_busy;
  assign bus.timeout_o = w_timeout;
endmodule

// File: tb/tb_cim_core_reg_arbiter.sv
// Self-checking bench for cim_core_reg_arbiter: directed scenarios plus randomized
// traffic compared every cycle against a transaction-level model.
module tb_cim_core_reg_arbiter;
  localparam int unsigned NR = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;
  localparam int          N  = 4;
  localparam int          TO = 8;
`ifdef CIM_REG_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          tv_valid [NR];
  logic          tv_write [NR];
  logic [AW-1:0] tv_addr  [NR];
  logic [DW-1:0] tv_wdata [NR];
  logic [SW-1:0] tv_wstrb [NR];
  logic          s_ready;
  logic [DW-1:0] s_rdata;
  logic          s_error;

  cim_core_reg_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  for (genvar g = 0; g < NR; g++) begin : g_drive
    assign bus.req_valid_i[g]            = tv_valid[g];
    assign bus.req_write_i[g]            = tv_write[g];
    assign bus.req_addr_i[g*AW +: AW]    = tv_addr[g];
    assign bus.req_wdata_i[g*DW +: DW]   = tv_wdata[g];
    assign bus.req_wstrb_i[g*SW +: SW]   = tv_wstrb[g];
  end
  assign bus.out_ready_i = s_ready;
  assign bus.out_rdata_i = s_rdata;
  assign bus.out_error_i = s_error;

  cim_core_reg_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) u_dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Transaction-level model: who owns the bus (-1 = nobody), pointer, cycles spent owning.
  int m_cur = -1;
  int m_ptr = 0;
  int m_age = 0;

  function automatic int m_pick();
    int best, bestd, d;
    best  = -1;
    bestd = N;
    for (int i = 0; i < N; i++) begin
      d = (i - m_ptr + N) % N;
      if (tv_valid[i] && d < bestd) begin
        best  = i;
        bestd = d;
      end
    end
    return best;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cur = -1;
      m_ptr = 0;
      m_age = 0;
    end else if (m_cur < 0) begin
      m_cur = m_pick();
      m_age = 0;
    end else begin
      bit gv, fin;
      gv  = tv_valid[m_cur];
      fin = gv && (s_ready || (TO_EN && m_age == TO - 1));
      if (fin) begin
        m_ptr = (m_cur + 1) % N;
        m_cur = -1;
      end else if (!gv) begin
        m_cur = -1;
      end else begin
        m_age++;
      end
    end
  end

  always @(negedge clk) begin
    logic [NR-1:0] e_grant, e_ready;
    logic          e_valid, e_write, e_busy, e_err, e_to, gv, ack, tmo;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_rdata;
    logic [SW-1:0] e_wstrb;
    e_grant = '0; e_ready = '0; e_valid = 1'b0; e_write = 1'b0; e_busy = 1'b0;
    e_err = 1'b0; e_to = 1'b0; e_addr = '0; e_wdata = '0; e_rdata = '0; e_wstrb = '0;
    if (m_cur >= 0) begin
      gv      = tv_valid[m_cur];
      ack     = gv && s_ready;
      tmo     = TO_EN && gv && !s_ready && (m_age == TO - 1);
      e_busy  = 1'b1;
      e_grant = NR'(1) << m_cur;
      e_valid = gv;
      e_write = tv_write[m_cur];
      e_addr  = tv_addr[m_cur];
      e_wdata = tv_wdata[m_cur];
      e_wstrb = tv_wstrb[m_cur];
      if (ack || tmo) e_ready = e_grant;
      if (ack && !tv_write[m_cur]) e_rdata = s_rdata;
      e_err = ack ? s_error : tmo;
      e_to  = tmo;
    end
    check("m_out_valid", 64'(bus.out_valid_o), 64'(e_valid));
    check("m_out_write", 64'(bus.out_write_o), 64'(e_write));
    check("m_out_addr",  64'(bus.out_addr_o),  64'(e_addr));
    check("m_out_wdata", 64'(bus.out_wdata_o), 64'(e_wdata));
    check("m_out_wstrb", 64'(bus.out_wstrb_o), 64'(e_wstrb));
    check("m_grant",     64'(bus.grant_o),     64'(e_grant));
    check("m_busy",      64'(bus.busy_o),      64'(e_busy));
    check("m_ready",     64'(bus.req_ready_o), 64'(e_ready));
    check("m_rdata",     64'(bus.req_rdata_o), 64'(e_rdata));
    check("m_error",     64'(bus.req_error_o), 64'(e_err));
    check("m_timeout",   64'(bus.timeout_o),   64'(e_to));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) begin
      tv_valid[i] = 1'b0;
      tv_write[i] = 1'b0;
      tv_addr[i]  = '0;
      tv_wdata[i] = '0;
      tv_wstrb[i] = '0;
    end
    s_ready = 1'b0;
    s_rdata = '0;
    s_error = 1'b0;
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    clear_reqs();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [NR-1:0] grants [$];
    logic [NR-1:0] exp_b [5];
    logic [NR-1:0] last_ready;
    int            k_done, cnt;

    clear_reqs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
    check("rst_grant",     64'(bus.grant_o),     64'd0);
    check("rst_busy",      64'(bus.busy_o),      64'd0);
    step();
    rst_n = 1'b1;

    // Single read from requester 0.
    step();
    tv_valid[0] = 1'b1;
    tv_addr[0]  = 32'h40;
    @(negedge clk);
    check("A_idle_valid", 64'(bus.out_valid_o), 64'd0);
    step();
    s_ready = 1'b1;
    s_rdata = 32'hDEADBEEF;
    @(negedge clk);
    check("A_out_valid", 64'(bus.out_valid_o), 64'd1);
    check("A_out_addr",  64'(bus.out_addr_o),  64'h40);
    check("A_ready",     64'(bus.req_ready_o), 64'b0001);
    check("A_rdata",     64'(bus.req_rdata_o), 64'hDEADBEEF);
    step();
    tv_valid[0] = 1'b0;
    s_ready     = 1'b0;
    @(negedge clk);
    check("A_back_idle", 64'(bus.busy_o), 64'd0);

    // All four requesting continuously, immediate acks.
    do_reset();
    for (int i = 0; i < N; i++) begin
      tv_valid[i] = 1'b1;
      tv_addr[i]  = AW'(32'h100 + 32'(i) * 4);
    end
    s_ready = 1'b1;
    exp_b = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int k = 0; k < 10; k++) begin
      step();
      @(negedge clk);
      if (bus.req_ready_o != '0) begin
        grants.push_back(bus.req_ready_o);
        check("B_cadence", 64'(k % 2), 64'd0);
      end
    end
    check("B_count", 64'(grants.size()), 64'd5);
    for (int i = 0; i < 5 && i < grants.size(); i++) check("B_order", 64'(grants[i]), 64'(exp_b[i]));

    // Pointer at 2 with requesters 0 and 3 pending.
    do_reset();
    tv_valid[1] = 1'b1;
    step();
    s_ready = 1'b1;
    step();
    tv_valid[1] = 1'b0;
    tv_valid[0] = 1'b1;
    tv_valid[3] = 1'b1;
    grants.delete();
    for (int k = 0; k < 4; k++) begin
      step();
      @(negedge clk);
      if (bus.req_ready_o != '0) grants.push_back(bus.req_ready_o);
    end
    check("C_count", 64'(grants.size()), 64'd2);
    if (grants.size() >= 2) begin
      check("C_first",  64'(grants[0]), 64'b1000);
      check("C_second", 64'(grants[1]), 64'b0001);
    end

    // Write with partial strobes answered by an error.
    do_reset();
    tv_valid[2] = 1'b1;
    tv_write[2] = 1'b1;
    tv_addr[2]  = 32'h80;
    tv_wdata[2] = 32'hCAFEF00D;
    tv_wstrb[2] = 4'b0011;
    s_error     = 1'b1;
    s_rdata     = 32'h12345678;
    for (int k = 1; k <= 3; k++) begin
      step();
      if (k == 3) s_ready = 1'b1;
      @(negedge clk);
      check("D_wstrb", 64'(bus.out_wstrb_o), 64'b0011);
      check("D_write", 64'(bus.out_write_o), 64'd1);
      if (k == 3) begin
        check("D_ready", 64'(bus.req_ready_o), 64'b0100);
        check("D_error", 64'(bus.req_error_o), 64'd1);
        check("D_rdata", 64'(bus.req_rdata_o), 64'd0);
      end else begin
        check("D_wait", 64'(bus.req_ready_o), 64'd0);
      end
    end
    step();
    clear_reqs();

    // Slave never acknowledges.
    do_reset();
    tv_valid[1] = 1'b1;
    tv_addr[1]  = 32'h200;
    s_rdata     = 32'hA5A5A5A5;
`ifdef CIM_REG_ARB_TIMEOUT_EN
    k_done = -1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k_done > 0) tv_valid[1] = 1'b0;
      @(negedge clk);
      if (bus.req_ready_o != '0 && k_done < 0) begin
        k_done = k;
        check("E_to_pulse", 64'(bus.timeout_o),   64'd1);
        check("E_to_ready", 64'(bus.req_ready_o), 64'b0010);
        check("E_to_error", 64'(bus.req_error_o), 64'd1);
        check("E_to_rdata", 64'(bus.req_rdata_o), 64'd0);
      end
    end
    check("E_to_cycle", 64'(k_done), 64'd8);
    check("E_to_idle",  64'(bus.busy_o), 64'd0);
`else
    cnt = 0;
    for (int k = 1; k <= 100; k++) begin
      step();
      @(negedge clk);
      if (bus.out_valid_o && bus.req_ready_o == '0) cnt++;
    end
    check("E_hold_100", 64'(cnt), 64'd100);
    step();
    tv_valid[1] = 1'b0;
    @(negedge clk);
    check("E_drop_valid", 64'(bus.out_valid_o), 64'd0);
    check("E_drop_ready", 64'(bus.req_ready_o), 64'd0);
    step();
    @(negedge clk);
    check("E_drop_idle", 64'(bus.busy_o), 64'd0);
    k_done = 0;
`endif

    // Reset asserted in the middle of a transfer.
    do_reset();
    tv_valid[2] = 1'b1;
    step();
    @(negedge clk);
    check("F_busy_pre", 64'(bus.busy_o), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("F_valid_rst", 64'(bus.out_valid_o), 64'd0);
    check("F_grant_rst", 64'(bus.grant_o),     64'd0);
    check("F_busy_rst",  64'(bus.busy_o),      64'd0);
    step();
    for (int i = 0; i < N; i++) tv_valid[i] = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    @(negedge clk);
    check("F_first_grant", 64'(bus.grant_o), 64'b0001);

    // Randomized traffic; the per-cycle model comparison does the checking.
    do_reset();
    last_ready = '0;
    for (int k = 0; k < 3000; k++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (tv_valid[i]) begin
          if (((last_ready >> i) & NR'(1)) != '0 || $urandom_range(499) == 0) tv_valid[i] = 1'b0;
        end else if ($urandom_range(3) == 0) begin
          tv_valid[i] = 1'b1;
          tv_write[i] = 1'($urandom_range(1));
          tv_addr[i]  = AW'($urandom);
          tv_wdata[i] = DW'($urandom);
          tv_wstrb[i] = SW'($urandom);
        end
      end
      s_ready = ($urandom_range(99) < 40);
      s_rdata = DW'($urandom);
      s_error = ($urandom_range(7) == 0);
      @(negedge clk);
      last_ready = bus.req_ready_o;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
